// File: rtl/ex_memreq_queue_if.sv
// Request/bus bundle for the execute-stage memory request queue.
// The slave modport is the queue's own view; master is the execute stage and bus side.
interface ex_memreq_queue_if #(
  parameter int AW    = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush_i;
  logic          req_valid_i;
  logic [11:0]   req_memop_i;
  logic [AW-1:0] req_addr_i;
  logic [31:0]   req_wdata_i;
  logic          req_ready_o;
  logic          stallreq_o;
  logic          exc_adel_o;
  logic          exc_ades_o;
  logic          bus_valid_o;
  logic          bus_ready_i;
  logic          bus_wr_o;
  logic [AW-1:0] bus_addr_o;
  logic [1:0]    bus_size_o;
  logic [3:0]    bus_wstrb_o;
  logic [31:0]   bus_wdata_o;
  logic [CW-1:0] count_o;

  modport slave (
    input  flush_i, req_valid_i, req_memop_i, req_addr_i, req_wdata_i, bus_ready_i,
    output req_ready_o, stallreq_o, exc_adel_o, exc_ades_o,
    output bus_valid_o, bus_wr_o, bus_addr_o, bus_size_o, bus_wstrb_o, bus_wdata_o, count_o
  );

  modport master (
    output flush_i, req_valid_i, req_memop_i, req_addr_i, req_wdata_i, bus_ready_i,
    input  req_ready_o, stallreq_o, exc_adel_o, exc_ades_o,
    input  bus_valid_o, bus_wr_o, bus_addr_o, bus_size_o, bus_wstrb_o, bus_wdata_o, count_o
  );
endinterface

// File: rtl/ex_memreq_queue.sv
// Memory request queue between execute stage and data bus; encodes size/strobes/data at enqueue.
// MEMQ_UNALIGNED_EN enables lwl/lwr/swl/swr; otherwise they behave as lw/sw.
module ex_memreq_queue #(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input logic clk,
  input logic rst,
  ex_memreq_queue_if.slave io
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic          r_wr   [DEPTH];
  logic [AW-1:0] r_addr [DEPTH];
  logic [1:0]    r_size [DEPTH];
  logic [3:0]    r_strb [DEPTH];
  logic [31:0]   r_data [DEPTH];

  logic [11:0] w_m;
  logic [1:0]  w_a;
  logic [31:0] w_rt;
  logic        w_lw, w_sw, w_lwl, w_lwr, w_swl, w_swr;
  logic        w_full, w_accept, w_deq;
  logic        w_wr;
  logic [1:0]  w_size;
  logic [3:0]  w_strb;
  logic [31:0] w_data;

  // memop bits: 0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw, 5 sb, 6 sh, 7 sw, 8 lwl, 9 lwr, 10 swl, 11 swr
  assign w_m  = io.req_memop_i;
  assign w_a  = io.req_addr_i[1:0];
  assign w_rt = io.req_wdata_i;

`ifdef MEMQ_UNALIGNED_EN
  assign w_lw  = w_m[4];
  assign w_sw  = w_m[7];
  assign w_lwl = w_m[8];
  assign w_lwr = w_m[9];
  assign w_swl = w_m[10];
  assign w_swr = w_m[11];
`else
  assign w_lw  = w_m[4] | w_m[8] | w_m[9];
  assign w_sw  = w_m[7] | w_m[10] | w_m[11];
  assign w_lwl = 1'b0;
  assign w_lwr = 1'b0;
  assign w_swl = 1'b0;
  assign w_swr = 1'b0;
`endif

  assign io.exc_adel_o = io.req_valid_i & (((w_m[2] | w_m[3]) & w_a[0]) | (w_lw & (|w_a)));
  assign io.exc_ades_o = io.req_valid_i & ((w_m[6] & w_a[0]) | (w_sw & (|w_a)));

  assign w_full         = (r_count == CNT_FULL);
  assign io.req_ready_o = ~w_full;
  assign io.stallreq_o  = io.req_valid_i & (|w_m) & w_full;
  assign w_accept = io.req_valid_i & ~w_full & (|w_m) & ~io.exc_adel_o & ~io.exc_ades_o
                  & ~io.flush_i;
  assign w_deq    = io.bus_valid_o & io.bus_ready_i;

  always_comb begin
    w_wr   = 1'b0;
    w_size = 2'b00;
    w_strb = 4'b0000;
    w_data = 32'h0;
    if (w_m[2] | w_m[3]) begin
      w_size = 2'b01;
    end else if (w_lw) begin
      w_size = 2'b10;
    end else if (w_lwl) begin
      w_size = (w_a == 2'd0) ? 2'b00 : (w_a == 2'd1) ? 2'b01 : 2'b10;
    end else if (w_lwr) begin
      w_size = (w_a == 2'd3) ? 2'b00 : (w_a == 2'd2) ? 2'b01 : 2'b10;
    end else if (w_m[5]) begin
      w_wr = 1'b1;
      w_data = {4{w_rt[7:0]}};
      case (w_a)
        2'd0:    w_strb = 4'b0001;
        2'd1:    w_strb = 4'b0010;
        2'd2:    w_strb = 4'b0100;
        default: w_strb = 4'b1000;
      endcase
    end else if (w_m[6]) begin
      w_wr   = 1'b1;
      w_size = 2'b01;
      w_strb = w_a[1] ? 4'b1100 : 4'b0011;
      w_data = {2{w_rt[15:0]}};
    end else if (w_sw) begin
      w_wr   = 1'b1;
      w_size = 2'b10;
      w_strb = 4'b1111;
      w_data = w_rt;
    end else if (w_swl) begin
      w_wr = 1'b1;
      case (w_a)
        2'd0: begin w_size = 2'b00; w_strb = 4'b0001; w_data = {4{w_rt[31:24]}};    end
        2'd1: begin w_size = 2'b01; w_strb = 4'b0011; w_data = {2{w_rt[31:16]}};    end
        2'd2: begin w_size = 2'b10; w_strb = 4'b0111; w_data = {8'b0, w_rt[31:8]}; end
        default: begin w_size = 2'b10; w_strb = 4'b1111; w_data = w_rt;            end
      endcase
    end else if (w_swr) begin
      w_wr = 1'b1;
      case (w_a)
        2'd0: begin w_size = 2'b10; w_strb = 4'b1111; w_data = w_rt;                end
        2'd1: begin w_size = 2'b10; w_strb = 4'b1110; w_data = {w_rt[23:0], 8'b0}; end
        2'd2: begin w_size = 2'b01; w_strb = 4'b1100; w_data = {2{w_rt[15:0]}};    end
        default: begin w_size = 2'b00; w_strb = 4'b1000; w_data = {4{w_rt[7:0]}};  end
      endcase
    end
  end

  // Flush drops everything; a head handshake in the same cycle has already completed on the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_wr[i]   <= 1'b0;
        r_addr[i] <= '0;
        r_size[i] <= 2'b00;
        r_strb[i] <= 4'b0000;
        r_data[i] <= 32'h0;
      end
    end else if (io.flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_wr[r_tail]   <= w_wr;
        r_addr[r_tail] <= io.req_addr_i;
        r_size[r_tail] <= w_size;
        r_strb[r_tail] <= w_strb;
        r_data[r_tail] <= w_data;
        r_tail         <= r_tail + PTR_ONE;
      end
      if (w_deq) r_head <= r_head + PTR_ONE;
      if (w_accept && !w_deq)      r_count <= r_count + CNT_ONE;
      else if (!w_accept && w_deq) r_count <= r_count - CNT_ONE;
    end
  end

  assign io.bus_valid_o = (r_count != '0);
  assign io.bus_wr_o    = r_wr[r_head];
  assign io.bus_addr_o  = r_addr[r_head];
  assign io.bus_size_o  = r_size[r_head];
  assign io.bus_wstrb_o = r_strb[r_head];
  assign io.bus_wdata_o = r_data[r_head];
  assign io.count_o     = r_count;
endmodule
